// File: rtl/pulse_detect_ctrl.sv
// Run controller for the serial pattern detector: arms on start, counts
// overlapping pattern hits on data_in and reports the result over valid/ready.
module pulse_detect_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 16,
  parameter int HIT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [3:0]       cfg_len,
  input  logic [CNT_W-1:0] cfg_window,
  input  logic [HIT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             abort,
  input  logic             data_in,
  output logic             busy,
  output logic             done,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [HIT_W-1:0] evt_count,
  output logic             evt_timeout
);

  localparam int LEN_W = $clog2(PAT_W + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN,
    REPORT
  } state_t;

  state_t r_state;
  state_t w_state_n;

  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic [HIT_W-1:0] r_target;
  logic             r_window_en;
  logic [CNT_W-1:0] r_wcnt;
  logic [PAT_W-1:0] r_hist;
  logic [LEN_W-1:0] r_fill;
  logic [HIT_W-1:0] r_hits;
  logic [HIT_W-1:0] r_count;
  logic             r_timeout;
  logic             r_done;

  logic [LEN_W-1:0] w_len_eff;
  logic [HIT_W-1:0] w_target_eff;
  logic [PAT_W-1:0] w_hist_n;
  logic [LEN_W-1:0] w_fill_n;
  logic [PAT_W-1:0] w_mask;
  logic             w_match;
  logic [HIT_W-1:0] w_hits_n;
  logic             w_hit_done;
  logic             w_win_done;
  logic             w_accept;

  // Length 0 behaves as 1 and anything longer than the history is clamped.
  always_comb begin
    if (cfg_len == 4'd0) begin
      w_len_eff = LEN_W'(1);
    end else if (32'(cfg_len) > PAT_W) begin
      w_len_eff = LEN_MAX;
    end else begin
      w_len_eff = LEN_W'(cfg_len);
    end
  end

  assign w_target_eff = (cfg_target == '0) ? HIT_W'(1) : cfg_target;

  assign w_hist_n   = {r_hist[PAT_W-2:0], data_in};
  assign w_fill_n   = (r_fill == LEN_MAX) ? r_fill : r_fill + LEN_W'(1);
  assign w_mask     = {PAT_W{1'b1}} >> (LEN_MAX - r_len);
  assign w_match    = (w_fill_n >= r_len) && (((w_hist_n ^ r_pat) & w_mask) == '0);
  assign w_hits_n   = (w_match && (r_hits != '1)) ? r_hits + HIT_W'(1) : r_hits;
  assign w_hit_done = (w_hits_n >= r_target);
  assign w_win_done = r_window_en && (r_wcnt == CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Abort wins over start and evt_ready; target completion wins over expiry.
  always_comb begin
    w_state_n = r_state;
    w_accept  = 1'b0;
    busy      = (r_state != IDLE);
    evt_valid = (r_state == REPORT);
    case (r_state)
      IDLE: begin
        if (start && !abort) w_state_n = ARM;
      end
      ARM: begin
        w_state_n = abort ? IDLE : RUN;
      end
      RUN: begin
        if (abort) begin
          w_state_n = IDLE;
        end else if (w_hit_done || w_win_done) begin
          w_state_n = REPORT;
        end
      end
      REPORT: begin
        if (abort) begin
          w_state_n = IDLE;
        end else if (evt_ready) begin
          w_state_n = IDLE;
          w_accept  = 1'b1;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pat       <= '0;
      r_len       <= LEN_W'(1);
      r_target    <= HIT_W'(1);
      r_window_en <= 1'b0;
      r_wcnt      <= '0;
      r_hist      <= '0;
      r_fill      <= '0;
      r_hits      <= '0;
      r_count     <= '0;
      r_timeout   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_accept;
      case (r_state)
        ARM: begin
          r_pat       <= cfg_pattern;
          r_len       <= w_len_eff;
          r_target    <= w_target_eff;
          r_window_en <= (cfg_window != '0);
          r_wcnt      <= cfg_window;
          r_hist      <= '0;
          r_fill      <= '0;
          r_hits      <= '0;
          r_count     <= '0;
          r_timeout   <= 1'b0;
        end
        RUN: begin
          if (!abort) begin
            r_hist <= w_hist_n;
            r_fill <= w_fill_n;
            r_hits <= w_hits_n;
            if (r_window_en) r_wcnt <= r_wcnt - CNT_W'(1);
            // The result is frozen here so it stays stable under backpressure.
            if (w_hit_done) begin
              r_count   <= w_hits_n;
              r_timeout <= 1'b0;
            end else if (w_win_done) begin
              r_count   <= w_hits_n;
              r_timeout <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign done        = r_done;
  assign evt_count   = r_count;
  assign evt_timeout = r_timeout;

endmodule

// File: tb/tb_pulse_detect_ctrl.sv
// Directed bench for pulse_detect_ctrl; expected events come from a small
// reference model and are queued at start, then popped on each handshake.
module tb_pulse_detect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic [15:0] cfg_window;
  logic [7:0]  cfg_target;
  logic        start;
  logic        abort;
  logic        data_in;
  logic        busy;
  logic        done;
  logic        evt_valid;
  logic        evt_ready;
  logic [7:0]  evt_count;
  logic        evt_timeout;

  typedef struct {
    int count;
    int timeout;
    int cycles;
  } sbEntry_t;

  sbEntry_t sb[$];
  int tests = 0;
  int fails = 0;
  int cyc;

  pulse_detect_ctrl #(.PAT_W(8), .CNT_W(16), .HIT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len),
    .cfg_window(cfg_window),
    .cfg_target(cfg_target),
    .start(start),
    .abort(abort),
    .data_in(data_in),
    .busy(busy),
    .done(done),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_count(evt_count),
    .evt_timeout(evt_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference run: shift history, count overlapping matches, stop on target or window.
  function automatic void modelRun(input logic [7:0] pat, input logic [3:0] len,
                                   input logic [15:0] win, input logic [7:0] tgt,
                                   input logic [63:0] stream, input int nbits,
                                   output sbEntry_t e);
    int L;
    int T;
    int fill;
    int hits;
    logic [7:0] hist;
    logic [7:0] mask;
    logic b;
    L    = (len == 0) ? 1 : ((len > 8) ? 8 : int'(len));
    T    = (tgt == 0) ? 1 : int'(tgt);
    fill = 0;
    hits = 0;
    hist = 8'h00;
    mask = 8'hFF >> (8 - L);
    e.count   = 0;
    e.timeout = 0;
    e.cycles  = -1;
    for (int i = 0; i < 200; i++) begin
      b    = (i < nbits) ? stream[i] : 1'b0;
      hist = {hist[6:0], b};
      if (fill < 8) fill++;
      if (fill >= L && ((hist ^ pat) & mask) == 8'h00 && hits < 255) hits++;
      if (hits >= T) begin
        e.count = hits; e.timeout = 0; e.cycles = i + 1;
        return;
      end
      if (win != 0 && (i + 1) == int'(win)) begin
        e.count = hits; e.timeout = 1; e.cycles = i + 1;
        return;
      end
    end
  endfunction

  task automatic applyStimulus(input logic [7:0] pat, input logic [3:0] len,
                               input logic [15:0] win, input logic [7:0] tgt,
                               input logic [63:0] stream, input int nbits,
                               input bit lateStart, output int runCycles);
    sbEntry_t e;
    modelRun(pat, len, win, tgt, stream, nbits, e);
    sb.push_back(e);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_window  = win;
    cfg_target  = tgt;
    start       = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("arm_busy", busy, 1);
    checkOutput("arm_no_valid", evt_valid, 0);
    tick();
    checkOutput("arm_clear_count", evt_count, 0);
    checkOutput("arm_clear_timeout", evt_timeout, 0);
    cfg_pattern = ~pat;
    cfg_len     = 4'd1;
    cfg_window  = 16'd1;
    cfg_target  = 8'd1;
    runCycles = 0;
    while (!evt_valid && runCycles < 200) begin
      data_in = (runCycles < nbits) ? stream[runCycles] : 1'b0;
      start   = lateStart && (runCycles == 1);
      tick();
      runCycles++;
    end
    start   = 1'b0;
    data_in = 1'b0;
    checkOutput("latency", runCycles, e.cycles);
  endtask

  task automatic drainEvent(input int hold);
    sbEntry_t e;
    if (sb.size() == 0) begin
      checkOutput("sb_nonempty", 0, 1);
      return;
    end
    e = sb.pop_front();
    evt_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      checkOutput("bp_valid", evt_valid, 1);
      checkOutput("bp_count", evt_count, e.count);
      checkOutput("bp_timeout", evt_timeout, e.timeout);
      tick();
    end
    checkOutput("evt_valid", evt_valid, 1);
    checkOutput("evt_count", evt_count, e.count);
    checkOutput("evt_timeout", evt_timeout, e.timeout);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    checkOutput("done_pulse", done, 1);
    checkOutput("done_busy", busy, 0);
    checkOutput("done_valid", evt_valid, 0);
    checkOutput("idle_count_hold", evt_count, e.count);
    tick();
    checkOutput("done_once", done, 0);
    checkOutput("idle_busy", busy, 0);
  endtask

  initial begin
    rst         = 1'b1;
    cfg_pattern = 8'h00;
    cfg_len     = 4'd0;
    cfg_window  = 16'd0;
    cfg_target  = 8'd0;
    start       = 1'b0;
    abort       = 1'b0;
    data_in     = 1'b0;
    evt_ready   = 1'b0;
    repeat (2) tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_valid", evt_valid, 0);
    checkOutput("rst_count", evt_count, 0);
    checkOutput("rst_timeout", evt_timeout, 0);
    rst = 1'b0;
    tick();

    // Basic overlapping hits: 010 on 0,1,0,1,0 -> 2 hits, no timeout.
    applyStimulus(8'h02, 4'd3, 16'd0, 8'd2, 64'h0A, 5, 1'b0, cyc);
    drainEvent(0);

    // Window expiry with backpressure on the event port.
    applyStimulus(8'h02, 4'd3, 16'd6, 8'd5, 64'h02, 6, 1'b0, cyc);
    drainEvent(4);

    // Second hit on the last window cycle still reaches the target.
    applyStimulus(8'h02, 4'd3, 16'd5, 8'd2, 64'h0A, 5, 1'b0, cyc);
    drainEvent(1);

    // Start pulsed during RUN must be ignored.
    applyStimulus(8'h02, 4'd3, 16'd0, 8'd2, 64'h0A, 5, 1'b1, cyc);
    drainEvent(0);

    // Abort on RUN cycle 2.
    cfg_pattern = 8'h02; cfg_len = 4'd3; cfg_window = 16'd0; cfg_target = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    data_in = 1'b0;
    tick();
    data_in = 1'b1;
    abort   = 1'b1;
    tick();
    abort   = 1'b0;
    data_in = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_valid", evt_valid, 0);
    checkOutput("abort_done", done, 0);
    tick();
    checkOutput("abort_done_late", done, 0);
    checkOutput("abort_valid_late", evt_valid, 0);

    // Abort together with start in IDLE keeps the block idle.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checkOutput("abort_over_start", busy, 0);

    // Reset while an event is pending.
    applyStimulus(8'h02, 4'd3, 16'd0, 8'd2, 64'h0A, 5, 1'b0, cyc);
    checkOutput("pre_rst_valid", evt_valid, 1);
    rst = 1'b1;
    #1;
    checkOutput("rst_rep_busy", busy, 0);
    checkOutput("rst_rep_valid", evt_valid, 0);
    checkOutput("rst_rep_count", evt_count, 0);
    checkOutput("rst_rep_timeout", evt_timeout, 0);
    checkOutput("rst_rep_done", done, 0);
    sb.delete();
    tick();
    rst = 1'b0;
    tick();

    // Clean run after reset, then length 0 treated as 1.
    applyStimulus(8'h02, 4'd3, 16'd0, 8'd2, 64'h0A, 5, 1'b0, cyc);
    drainEvent(0);
    applyStimulus(8'h01, 4'd0, 16'd0, 8'd2, 64'h03, 2, 1'b0, cyc);
    drainEvent(0);

    // Length clamped to 8, target 0 treated as 1.
    applyStimulus(8'hA5, 4'd15, 16'd20, 8'd0, 64'hA5, 8, 1'b0, cyc);
    drainEvent(2);

    // Pseudo-random streams checked against the model.
    applyStimulus(8'h05, 4'd3, 16'd40, 8'd200, {$urandom, $urandom}, 64, 1'b0, cyc);
    drainEvent(1);
    applyStimulus(8'h06, 4'd4, 16'd60, 8'd3, {$urandom, $urandom}, 64, 1'b0, cyc);
    drainEvent(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pulse_detect_ctrl.md
Name: pulse_detect_ctrl

Overview:
Run-controller for the serial pattern detector path. Software loads a pattern of 1..PAT_W bits, an observation window and a hit target, then pulses start. The block watches data_in for overlapping pattern matches, counts them, and finishes when the target is reached or the window expires. It reports the result through a valid/ready event port and returns to idle.

Parameters:
PAT_W, 8, maximum pattern length in bits; must be at least 2.
CNT_W, 16, width of the window counter and of cfg_window.
HIT_W, 8, width of the hit counter, cfg_target and evt_count.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  asynchronous, active-high reset.
cfg_pattern  in  PAT_W  pattern to match; bit 0 is the most recent bit.
cfg_len  in  4  pattern length; 0 is treated as 1; values above PAT_W are clamped to PAT_W.
cfg_window  in  CNT_W  run length in cycles; 0 means unlimited.
cfg_target  in  HIT_W  number of hits that ends the run; 0 is treated as 1.
start  in  1  one-cycle request to begin a run; honoured only in IDLE.
abort  in  1  stops the run and returns to IDLE without an event.
data_in  in  1  serial input; sampled only in RUN.
busy  out  1  high in ARM, RUN and REPORT.
done  out  1  one-cycle pulse when an event is accepted.
evt_valid  out  1  result available.
evt_ready  in  1  consumer accepts the result.
evt_count  out  HIT_W  number of hits in the run.
evt_timeout  out  1  1 means the window expired before the target was reached.

Behaviour:
- Reset: state=IDLE. busy, done, evt_valid, evt_count and evt_timeout are all 0. History, fill, hit and window registers are cleared. Reset takes effect immediately in any state, including mid-RUN and mid-REPORT, and any pending event is discarded.
- FSM states: IDLE, ARM, RUN, REPORT.
- IDLE -> ARM when start=1 and abort=0.
- ARM (1 cycle):
  - latch pattern, effective length, window and target;
  - clear history, fill count and hit count;
  - load the window counter.
  - Next state is RUN.
- RUN, each cycle:
  - hist_n = {hist[PAT_W-2:0], data_in};
  - fill saturates at PAT_W;
  - match = (fill_n >= len) && (hist_n[len-1:0] == pat[len-1:0]).
  - Matches may overlap: pattern 010 on stream 01010 gives 2 hits.
  - hit_cnt increments on match and saturates at its all-ones value.
  - The window counter decrements each RUN cycle when window is nonzero.
- RUN exit:
  - Target reached: when hit_cnt+match reaches target, go to REPORT with timeout=0.
  - Window expired: otherwise, after exactly cfg_window RUN cycles, go to REPORT with timeout=1.
  - Simultaneous: a match on the final window cycle is counted. If it reaches the target, timeout=0.
- REPORT:
  - evt_valid=1; evt_count and evt_timeout stay stable while evt_valid=1 and evt_ready=0.
  - When evt_valid && evt_ready: go to IDLE, done=1 for that next cycle only, evt_valid drops.
  - Result latency from the exiting RUN sample to evt_valid is 1 cycle.
- Abort: abort=1 in ARM, RUN or REPORT goes to IDLE on the next edge, with no event and no done pulse. Abort overrides start and evt_ready in the same cycle.
- Config changes: cfg_* changes after ARM have no effect on the current run.
- start outside IDLE: ignored, with no queuing.
- evt_count and evt_timeout keep their last values in IDLE until the next ARM, which clears them.

Test Plan:
- Basic hits: pattern=3'b010 (len=3), target=2, window=0, data_in after ARM = 0,1,0,1,0 -> hits on RUN cycles 3 and 5; evt_valid the next cycle; evt_count=2, evt_timeout=0; done pulses 1 cycle after evt_ready.
- Timeout: same pattern, target=5, window=6, stream 0,1,0,0,0,0 -> REPORT after 6 RUN cycles; evt_count=1, evt_timeout=1.
- Simultaneous: window=5, target=2, stream 0,1,0,1,0 -> second hit lands on the last window cycle; evt_count=2, evt_timeout=0.
- Backpressure: hold evt_ready=0 for 4 cycles -> evt_valid, evt_count and evt_timeout stay stable; release -> single done pulse, busy=0.
- Abort and late start: abort on RUN cycle 2 -> IDLE next cycle, no evt_valid, no done. A start pulsed during RUN -> ignored, run completes normally.
- Reset and clamping: assert rst during REPORT -> all outputs 0 immediately; the next start runs cleanly. cfg_len=0, pattern bit0=1, stream 1,1 -> 2 hits.
